// File: rtl/leglite_pkg.sv
// leglite_pkg: shared definitions for the LEGLite hazard controller.
//   - opcode encodings of the 3-bit ID opcode field
//   - sequencing FSM state type
//   - shadow slot type tracking instructions bound for EX and MEM
package leglite_pkg;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_UNDEF = 3'd2;
    localparam logic [2:0] OP_LD    = 3'd3;
    localparam logic [2:0] OP_ST    = 3'd4;
    localparam logic [2:0] OP_CBZ   = 3'd5;
    localparam logic [2:0] OP_ADDI  = 3'd6;
    localparam logic [2:0] OP_ANDI  = 3'd7;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StBrWait1 = 2'd1,
        StBrWait2 = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       memread;
        logic [2:0] rd;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, wr: 1'b0, memread: 1'b0, rd: 3'd0};

endpackage

// File: rtl/leglite_regusage.sv
// leglite_regusage: combinational decode of which registers an ID-stage
// instruction reads and writes.
//   opcode, rn, rm, rd : instruction fields in ID
//   rd_a_en, rd_a      : first read port usage
//   rd_b_en, rd_b      : second read port usage
//   wr                 : instruction writes rd
//   memread            : instruction is a load
module leglite_regusage
    import leglite_pkg::*;
(
    input  logic [2:0] opcode,
    input  logic [2:0] rn,
    input  logic [2:0] rm,
    input  logic [2:0] rd,
    output logic       rd_a_en,
    output logic [2:0] rd_a,
    output logic       rd_b_en,
    output logic [2:0] rd_b,
    output logic       wr,
    output logic       memread
);

    always_comb begin
        rd_a_en = 1'b0;
        rd_a    = rn;
        rd_b_en = 1'b0;
        rd_b    = rm;
        wr      = 1'b0;
        memread = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: begin
                rd_a_en = 1'b1;
                rd_b_en = 1'b1;
                wr      = 1'b1;
            end
            OP_LD: begin
                rd_a_en = 1'b1;
                wr      = 1'b1;
                memread = 1'b1;
            end
            OP_ST: begin
                // Store data comes from the rd field.
                rd_a_en = 1'b1;
                rd_b_en = 1'b1;
                rd_b    = rd;
            end
            OP_CBZ: begin
                // CBZ tests the register named in rd.
                rd_a_en = 1'b1;
                rd_a    = rd;
            end
            OP_ADDI, OP_ANDI: begin
                rd_a_en = 1'b1;
                wr      = 1'b1;
            end
            default: ; // OP_UNDEF: bubble, no register usage
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: LEGLite ID-stage sequencing controller.
//   Resolves load-use hazards by a one-cycle stall and CBZ control hazards by
//   either predict-not-taken with flush (BR_POLICY=0) or holding fetch until
//   the branch resolves in MEM (BR_POLICY=1).
//   clock, reset_n          : rising-edge clock, async active-low reset
//   id_opcode/rn/rm/rd      : instruction fields in ID
//   mem_br_taken            : CBZ in MEM is taken
//   pc_write, ifid_write    : fetch / IF-ID load enables
//   nop                     : bubble into ID/EX
//   flush_ifid, flush_idex  : pipeline register clears
//   stall_cnt, flush_cnt    : saturating event counters
module pipeline_hazard_ctrl
    import leglite_pkg::*;
#(
    parameter int unsigned BR_POLICY = 0,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [2:0]       id_opcode,
    input  logic [2:0]       id_rn,
    input  logic [2:0]       id_rm,
    input  logic [2:0]       id_rd,
    input  logic             mem_br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             nop,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam bit PredictNt = (BR_POLICY == 0);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e state_q, state_d;
    slot_t  ex_slot_q, ex_slot_d;
    slot_t  mem_slot_q, mem_slot_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic       rd_a_en, rd_b_en, id_wr, id_memread;
    logic [2:0] rd_a, rd_b;
    logic       load_use;
    logic       stall_inc, flush_inc;
    logic       pc_write_c, ifid_write_c, nop_c, flush_ifid_c, flush_idex_c;

    leglite_regusage u_regusage (
        .opcode  (id_opcode),
        .rn      (id_rn),
        .rm      (id_rm),
        .rd      (id_rd),
        .rd_a_en (rd_a_en),
        .rd_a    (rd_a),
        .rd_b_en (rd_b_en),
        .rd_b    (rd_b),
        .wr      (id_wr),
        .memread (id_memread)
    );

    assign load_use = ex_slot_q.valid && ex_slot_q.memread &&
                      ((rd_a_en && (rd_a == ex_slot_q.rd)) ||
                       (rd_b_en && (rd_b == ex_slot_q.rd)));

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b1;
        ifid_write_c = 1'b1;
        nop_c        = 1'b0;
        flush_ifid_c = 1'b0;
        flush_idex_c = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        mem_slot_d   = ex_slot_q;
        case (state_q)
            StRun: begin
                if (PredictNt && mem_br_taken) begin
                    // Taken branch squashes IF/ID, ID/EX and EX/MEM-bound work.
                    nop_c        = 1'b1;
                    flush_ifid_c = 1'b1;
                    flush_idex_c = 1'b1;
                    flush_inc    = 1'b1;
                    mem_slot_d   = SLOT_EMPTY;
                end else if (load_use) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    nop_c        = 1'b1;
                    stall_inc    = 1'b1;
                end else if (!PredictNt && (id_opcode == OP_CBZ)) begin
                    state_d = StBrWait1;
                end
            end
            StBrWait1: begin
                // A taken report here is a protocol error and is ignored.
                pc_write_c   = 1'b0;
                ifid_write_c = 1'b0;
                nop_c        = 1'b1;
                stall_inc    = 1'b1;
                state_d      = StBrWait2;
            end
            StBrWait2: begin
                state_d = StRun;
                if (mem_br_taken) begin
                    nop_c        = 1'b1;
                    flush_ifid_c = 1'b1;
                    flush_inc    = 1'b1;
                end else if (load_use) begin
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    nop_c        = 1'b1;
                    stall_inc    = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        if (nop_c) begin
            ex_slot_d = SLOT_EMPTY;
        end else begin
            ex_slot_d = '{valid: 1'b1, wr: id_wr, memread: id_memread, rd: id_rd};
        end
    end

    // Hold the pipeline quiet while reset is asserted.
    assign pc_write   = reset_n & pc_write_c;
    assign ifid_write = reset_n & ifid_write_c;
    assign nop        = ~reset_n | nop_c;
    assign flush_ifid = reset_n & flush_ifid_c;
    assign flush_idex = reset_n & flush_idex_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StRun;
            ex_slot_q   <= SLOT_EMPTY;
            mem_slot_q  <= SLOT_EMPTY;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ex_slot_q  <= ex_slot_d;
            mem_slot_q <= mem_slot_d;
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    // Shadow state kept for visibility; not consumed by the control logic.
    logic unused_slots;
    assign unused_slots = ^{ex_slot_q.wr, mem_slot_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: one controller per branch policy, driven with shared ID
// fields; inputs change on the falling edge, outputs sampled 1ns later.
module tb_pipeline_hazard_ctrl;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, UND = 3'd2, LD = 3'd3;
    localparam logic [2:0] ST = 3'd4, CBZ = 3'd5, ADDI = 3'd6;

    logic       clock;
    logic       reset_n;
    logic [2:0] id_opcode, id_rn, id_rm, id_rd;
    logic       mem_br_taken;

    logic       p0_pc, p0_ifid, p0_nop, p0_fif, p0_fid;
    logic       p1_pc, p1_ifid, p1_nop, p1_fif, p1_fid;
    logic [7:0] p0_stall, p0_flush, p1_stall, p1_flush;

    int total = 0;
    int bad   = 0;

    pipeline_hazard_ctrl #(.BR_POLICY(0), .CNT_W(8)) u_dut_p0 (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_opcode    (id_opcode),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .mem_br_taken (mem_br_taken),
        .pc_write     (p0_pc),
        .ifid_write   (p0_ifid),
        .nop          (p0_nop),
        .flush_ifid   (p0_fif),
        .flush_idex   (p0_fid),
        .stall_cnt    (p0_stall),
        .flush_cnt    (p0_flush)
    );

    pipeline_hazard_ctrl #(.BR_POLICY(1), .CNT_W(8)) u_dut_p1 (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_opcode    (id_opcode),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .mem_br_taken (mem_br_taken),
        .pc_write     (p1_pc),
        .ifid_write   (p1_ifid),
        .nop          (p1_nop),
        .flush_ifid   (p1_fif),
        .flush_idex   (p1_fid),
        .stall_cnt    (p1_stall),
        .flush_cnt    (p1_flush)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one ID instruction for the coming cycle.
    task automatic step(input logic [2:0] op, input logic [2:0] rn, input logic [2:0] rm,
                        input logic [2:0] rd, input logic br);
        @(negedge clock);
        id_opcode    = op;
        id_rn        = rn;
        id_rm        = rm;
        id_rd        = rd;
        mem_br_taken = br;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n      = 1'b0;
        id_opcode    = UND;
        id_rn        = 3'd0;
        id_rm        = 3'd0;
        id_rd        = 3'd0;
        mem_br_taken = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b0;
        id_opcode    = UND;
        id_rn        = 3'd0;
        id_rm        = 3'd0;
        id_rd        = 3'd0;
        mem_br_taken = 1'b0;
        #1;
        check("rst_pc", p0_pc, 0);
        check("rst_ifid", p1_ifid, 0);
        check("rst_nop", p0_nop, 1);
        check("rst_flush_ifid", p0_fif, 0);
        check("rst_flush_idex", p1_fid, 0);
        check("rst_stall_cnt", p0_stall, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // LD r1 then dependent ADD: one stall cycle.
        step(LD, 3'd0, 3'd0, 3'd1, 1'b0);
        check("ld_issue_nop", p0_nop, 0);
        check("ld_issue_pc", p0_pc, 1);
        step(ADD, 3'd1, 3'd3, 3'd2, 1'b0);
        check("lu_rn_pc", p0_pc, 0);
        check("lu_rn_nop", p0_nop, 1);
        check("lu_rn_ifid", p1_ifid, 0);
        check("lu_cnt_before", p0_stall, 0);
        step(ADD, 3'd1, 3'd3, 3'd2, 1'b0);
        check("lu_release_pc", p0_pc, 1);
        check("lu_cnt_p0", p0_stall, 1);
        check("lu_cnt_p1", p1_stall, 1);
        // Dependence through rm.
        step(LD, 3'd0, 3'd0, 3'd4, 1'b0);
        step(SUB, 3'd3, 3'd4, 3'd2, 1'b0);
        check("lu_rm_nop", p0_nop, 1);
        step(SUB, 3'd3, 3'd4, 3'd2, 1'b0);
        check("lu_rm_cnt", p0_stall, 2);
        // Dependence through the store data register.
        step(LD, 3'd0, 3'd0, 3'd6, 1'b0);
        step(ST, 3'd2, 3'd0, 3'd6, 1'b0);
        check("lu_st_pc", p0_pc, 0);
        step(ST, 3'd2, 3'd0, 3'd6, 1'b0);
        check("lu_st_cnt", p0_stall, 3);
        // Bubble opcode reads nothing.
        step(LD, 3'd0, 3'd0, 3'd1, 1'b0);
        step(UND, 3'd1, 3'd1, 3'd1, 1'b0);
        check("undef_no_stall", p0_nop, 0);

        // No dependence.
        do_reset();
        step(LD, 3'd0, 3'd0, 3'd1, 1'b0);
        step(ADD, 3'd4, 3'd5, 3'd2, 1'b0);
        check("nodep_pc", p0_pc, 1);
        check("nodep_nop", p0_nop, 0);
        step(LD, 3'd0, 3'd0, 3'd1, 1'b0);
        step(ADDI, 3'd2, 3'd1, 3'd3, 1'b0);
        check("addi_rm_ignored", p0_nop, 0);
        step(ADDI, 3'd0, 3'd0, 3'd0, 1'b0);
        check("nodep_cnt", p0_stall, 0);

        // CBZ taken: policy 0 flushes, policy 1 waits then flushes IF/ID.
        do_reset();
        step(CBZ, 3'd0, 3'd0, 3'd5, 1'b0);
        check("cbz_issue_p0", p0_pc, 1);
        check("cbz_issue_p1", p1_pc, 1);
        step(ADDI, 3'd2, 3'd0, 3'd3, 1'b0);
        check("cbz_ex_p0_pc", p0_pc, 1);
        check("brwait1_p1_pc", p1_pc, 0);
        check("brwait1_p1_nop", p1_nop, 1);
        step(ADDI, 3'd2, 3'd0, 3'd3, 1'b1);
        check("taken_p0_fif", p0_fif, 1);
        check("taken_p0_fid", p0_fid, 1);
        check("taken_p0_nop", p0_nop, 1);
        check("taken_p0_pc", p0_pc, 1);
        check("taken_p1_fif", p1_fif, 1);
        check("taken_p1_fid", p1_fid, 0);
        check("taken_p1_nop", p1_nop, 1);
        check("taken_p1_pc", p1_pc, 1);
        step(ADDI, 3'd2, 3'd0, 3'd3, 1'b0);
        check("after_taken_p0_fif", p0_fif, 0);
        check("after_taken_p0_nop", p0_nop, 0);
        check("taken_p0_fcnt", p0_flush, 1);
        check("taken_p1_fcnt", p1_flush, 1);
        check("taken_p1_scnt", p1_stall, 1);
        check("after_taken_p1_pc", p1_pc, 1);

        // Policy 1, CBZ not taken: held instruction issues in BRWAIT2.
        do_reset();
        step(CBZ, 3'd0, 3'd0, 3'd5, 1'b0);
        step(ADDI, 3'd2, 3'd0, 3'd3, 1'b0);
        check("nt_brwait1_pc", p1_pc, 0);
        step(ADDI, 3'd2, 3'd0, 3'd3, 1'b0);
        check("nt_brwait2_pc", p1_pc, 1);
        check("nt_brwait2_nop", p1_nop, 0);
        check("nt_brwait2_fif", p1_fif, 0);
        step(ADD, 3'd1, 3'd2, 3'd4, 1'b0);
        check("nt_run_pc", p1_pc, 1);
        check("nt_scnt", p1_stall, 1);
        check("nt_fcnt", p1_flush, 0);

        // Taken flush coincident with load-use.
        do_reset();
        step(LD, 3'd0, 3'd0, 3'd1, 1'b0);
        step(ADD, 3'd1, 3'd3, 3'd2, 1'b1);
        check("coinc_p0_pc", p0_pc, 1);
        check("coinc_p0_fid", p0_fid, 1);
        check("coinc_p0_nop", p0_nop, 1);
        check("coinc_p1_stall_pc", p1_pc, 0);
        step(ADDI, 3'd0, 3'd0, 3'd0, 1'b0);
        check("coinc_p0_scnt", p0_stall, 0);
        check("coinc_p0_fcnt", p0_flush, 1);
        check("coinc_p1_scnt", p1_stall, 1);

        // Saturation: LD r1,[r1] held in ID stalls every other cycle.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(LD, 3'd1, 3'd0, 3'd1, 1'b0);
            if (i == 100) check("sat_mid_cnt", p0_stall, 100);
            step(LD, 3'd1, 3'd0, 3'd1, 1'b0);
        end
        step(ADDI, 3'd0, 3'd0, 3'd0, 1'b0);
        check("sat_p0_scnt", p0_stall, 255);
        check("sat_p1_scnt", p1_stall, 255);

        // Reset while policy 1 sits in BRWAIT1.
        step(CBZ, 3'd0, 3'd0, 3'd5, 1'b0);
        step(ADDI, 3'd2, 3'd0, 3'd3, 1'b0);
        check("pre_rst_brwait1_pc", p1_pc, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_bw_nop", p1_nop, 1);
        check("rst_bw_pc", p1_pc, 0);
        check("rst_bw_scnt", p1_stall, 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rel_run_pc", p1_pc, 1);
        check("rel_run_nop", p1_nop, 0);
        step(ADDI, 3'd2, 3'd0, 3'd3, 1'b0);
        check("rel_run2_pc", p1_pc, 1);
        check("rel_run2_scnt", p1_stall, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
